// File: rtl/gelato_fetch_warp_arbiter_if.sv
// gelato_fetch_warp_arbiter_if: fetch request channel from the warp arbiter to I-fetch.
// The master drives the request payload and valid. The slave (I-fetch) drives ready.
interface gelato_fetch_warp_arbiter_if #(
    parameter int ADDR_W    = 32,
    parameter int SPLIT_W   = 4,
    parameter int WARP_ID_W = 3
);
    logic                 fetch_valid;
    logic                 fetch_ready;
    logic [ADDR_W-1:0]    fetch_pc;
    logic [WARP_ID_W-1:0] fetch_warp_num;
    logic [SPLIT_W-1:0]   fetch_split_table_num;

    modport master (
        output fetch_valid,
        output fetch_pc,
        output fetch_warp_num,
        output fetch_split_table_num,
        input  fetch_ready
    );

    modport slave (
        input  fetch_valid,
        input  fetch_pc,
        input  fetch_warp_num,
        input  fetch_split_table_num,
        output fetch_ready
    );
endinterface

// File: rtl/gelato_fetch_warp_arbiter.sv
// gelato_fetch_warp_arbiter: tracks active warps and their in-flight fetch counts.
// Each cycle it picks one eligible warp and issues its PC to I-fetch over a
// valid/ready channel.
// Optional feature macro: GELATO_FETCH_GTO_EN. When it is defined, the last granted
// warp keeps the grant while it stays eligible (greedy-then-round-robin). When it is
// undefined, arbitration is strict round-robin.
module gelato_fetch_warp_arbiter #(
    parameter int WARP_NUM     = 8,
    parameter int ADDR_W       = 32,
    parameter int SPLIT_W      = 4,
    parameter int MAX_INFLIGHT = 1,
    parameter int WARP_ID_W    = $clog2(WARP_NUM),
    parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [WARP_NUM-1:0]              pc_valid,
    input  logic [WARP_NUM-1:0][ADDR_W-1:0]  pc,
    input  logic [WARP_NUM-1:0][SPLIT_W-1:0] split_table_num,
    input  logic                             activate_valid,
    input  logic [WARP_ID_W-1:0]             activate_warp_num,
    input  logic                             deactivate_valid,
    input  logic [WARP_ID_W-1:0]             deactivate_warp_num,
    gelato_fetch_warp_arbiter_if.master      fetch,
    input  logic                             resp_valid,
    input  logic [WARP_ID_W-1:0]             resp_warp_num,
    output logic [WARP_NUM-1:0]              warp_active
);
    localparam logic [CNT_W-1:0]     CNT_MAX    = CNT_W'(MAX_INFLIGHT);
    localparam logic [WARP_ID_W:0]   WARP_NUM_X = (WARP_ID_W + 1)'(WARP_NUM);
    localparam logic [WARP_ID_W-1:0] LAST_WARP  = WARP_ID_W'(WARP_NUM - 1);

    logic [WARP_NUM-1:0]  active_q;
    logic [CNT_W-1:0]     cnt_q [WARP_NUM];
    logic [WARP_ID_W-1:0] ptr_q;

    logic                 valid_q;
    logic [ADDR_W-1:0]    pc_q;
    logic [WARP_ID_W-1:0] warp_q;
    logic [SPLIT_W-1:0]   split_q;

    logic [WARP_NUM-1:0]  eligible;
    logic [WARP_NUM-1:0]  cnt_inc;
    logic [WARP_NUM-1:0]  cnt_dec;
    logic [WARP_ID_W:0]   scan_idx;
    logic                 rr_found;
    logic [WARP_ID_W-1:0] rr_grant;
    logic                 greedy_hit;
    logic                 grant_found;
    logic [WARP_ID_W-1:0] grant;
    logic                 out_free;
    logic                 load;

    // A warp may be granted only while active, with a valid PC and a free in-flight slot.
    always_comb begin
        eligible = '0;
        for (int w = 0; w < WARP_NUM; w++) begin
            eligible[w] = active_q[w] && pc_valid[w] && (cnt_q[w] < CNT_MAX);
        end
    end

    // Round-robin scan: the first eligible warp at or after the pointer, wrapping at WARP_NUM.
    always_comb begin
        rr_found = 1'b0;
        rr_grant = '0;
        scan_idx = '0;
        for (int i = 0; i < WARP_NUM; i++) begin
            scan_idx = {1'b0, ptr_q} + (WARP_ID_W + 1)'(i);
            if (scan_idx >= WARP_NUM_X) begin
                scan_idx = scan_idx - WARP_NUM_X;
            end
            if (!rr_found && eligible[scan_idx[WARP_ID_W-1:0]]) begin
                rr_found = 1'b1;
                rr_grant = scan_idx[WARP_ID_W-1:0];
            end
        end
    end

`ifdef GELATO_FETCH_GTO_EN
    logic [WARP_ID_W-1:0] last_q;
    logic                 last_valid_q;

    // Greedy path: keep granting the previous winner while it is still eligible.
    always_comb begin
        greedy_hit = last_valid_q && eligible[last_q];
    end

    // Remember the most recently granted warp for the greedy check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q       <= '0;
            last_valid_q <= 1'b0;
        end else if (load) begin
            last_q       <= grant;
            last_valid_q <= 1'b1;
        end
    end
`else
    assign greedy_hit = 1'b0;
`endif

    // Final grant selection and the output-register load condition.
    always_comb begin
        grant       = rr_grant;
        grant_found = rr_found;
`ifdef GELATO_FETCH_GTO_EN
        if (greedy_hit) begin
            grant       = last_q;
            grant_found = 1'b1;
        end
`endif
        out_free = !valid_q || fetch.fetch_ready;
        load     = out_free && grant_found;
    end

    // Per-warp counter events. A response to an idle warp is dropped unless it pairs with a load.
    always_comb begin
        cnt_inc = '0;
        cnt_dec = '0;
        for (int w = 0; w < WARP_NUM; w++) begin
            cnt_inc[w] = load && (grant == WARP_ID_W'(w));
            cnt_dec[w] = resp_valid && (resp_warp_num == WARP_ID_W'(w));
        end
    end

    // In-flight counters. A load and a response on the same warp in one cycle cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < WARP_NUM; w++) begin
                cnt_q[w] <= '0;
            end
        end else begin
            for (int w = 0; w < WARP_NUM; w++) begin
                if (cnt_inc[w] && !cnt_dec[w]) begin
                    cnt_q[w] <= cnt_q[w] + CNT_W'(1);
                end else if (!cnt_inc[w] && cnt_dec[w] && (cnt_q[w] != '0)) begin
                    cnt_q[w] <= cnt_q[w] - CNT_W'(1);
                end
            end
        end
    end

    // Active flags. The later clear gives deactivate priority over activate on the same warp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= '0;
        end else begin
            if (activate_valid) begin
                active_q[activate_warp_num] <= 1'b1;
            end
            if (deactivate_valid) begin
                active_q[deactivate_warp_num] <= 1'b0;
            end
        end
    end

    // Round-robin pointer moves past the winner, except on a greedy re-grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (load && !greedy_hit) begin
            ptr_q <= (grant == LAST_WARP) ? '0 : grant + WARP_ID_W'(1);
        end
    end

    // Request register. It holds its payload until accepted and drops valid if nothing is eligible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            warp_q  <= '0;
            split_q <= '0;
        end else begin
            if (out_free) begin
                valid_q <= grant_found;
            end
            if (load) begin
                pc_q    <= pc[grant];
                warp_q  <= grant;
                split_q <= split_table_num[grant];
            end
        end
    end

    assign fetch.fetch_valid           = valid_q;
    assign fetch.fetch_pc              = pc_q;
    assign fetch.fetch_warp_num        = warp_q;
    assign fetch.fetch_split_table_num = split_q;
    assign warp_active                 = active_q;

endmodule

// File: tb/tb_gelato_fetch_warp_arbiter.sv
// tb_gelato_fetch_warp_arbiter: table-driven vectors plus hand-written sequences for
// stalls, in-flight limits, async reset and the GELATO_FETCH_GTO_EN arbitration order.
// Accepted requests are compared against a queue of expected grants.
module tb_gelato_fetch_warp_arbiter;
    localparam int WN = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [WN-1:0]      pc_valid = '0;
    logic [WN-1:0][31:0] pc_tab;
    logic [WN-1:0][3:0] split_tab;
    logic               activate_valid = 1'b0;
    logic [1:0]         activate_warp_num = '0;
    logic               deactivate_valid = 1'b0;
    logic [1:0]         deactivate_warp_num = '0;
    logic               resp_valid = 1'b0;
    logic [1:0]         resp_warp_num = '0;
    logic [WN-1:0]      warp_active;

    gelato_fetch_warp_arbiter_if #(.ADDR_W(32), .SPLIT_W(4), .WARP_ID_W(2)) fetch_if ();

    gelato_fetch_warp_arbiter #(
        .WARP_NUM(WN), .ADDR_W(32), .SPLIT_W(4), .MAX_INFLIGHT(2)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .pc_valid            (pc_valid),
        .pc                  (pc_tab),
        .split_table_num     (split_tab),
        .activate_valid      (activate_valid),
        .activate_warp_num   (activate_warp_num),
        .deactivate_valid    (deactivate_valid),
        .deactivate_warp_num (deactivate_warp_num),
        .fetch               (fetch_if.master),
        .resp_valid          (resp_valid),
        .resp_warp_num       (resp_warp_num),
        .warp_active         (warp_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] pc_valid;
        logic       act_v;
        logic [1:0] act_w;
        logic       deact_v;
        logic [1:0] deact_w;
        logic       resp_v;
        logic [1:0] resp_w;
        logic       ready;
        logic       exp_valid;
        logic [1:0] exp_warp;
        logic [3:0] exp_active;
    } vec_t;

    typedef struct {
        logic [1:0]  warp;
        logic [31:0] pc;
        logic [3:0]  split;
    } exp_t;

    vec_t vecs [18];
    exp_t exp_q [$];
    logic [1:0] gto_exp [4];
    int n_checks = 0;
    int n_pass = 0;

    function automatic logic [31:0] model_pc(input logic [1:0] w);
        return 32'(w) * 32'h100;
    endfunction

    function automatic logic [3:0] model_split(input logic [1:0] w);
        return 4'(w) + 4'd5;
    endfunction

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic checkOutput(input string name, input logic exp_valid,
                               input logic [1:0] exp_warp, input logic [3:0] exp_active);
        checkValue({name, "_valid"}, 32'(fetch_if.fetch_valid), 32'(exp_valid));
        checkValue({name, "_active"}, 32'(warp_active), 32'(exp_active));
        if (exp_valid) begin
            checkValue({name, "_warp"}, 32'(fetch_if.fetch_warp_num), 32'(exp_warp));
            checkValue({name, "_pc"}, fetch_if.fetch_pc, model_pc(exp_warp));
            checkValue({name, "_split"}, 32'(fetch_if.fetch_split_table_num), 32'(model_split(exp_warp)));
        end
    endtask

    task automatic push_expect(input logic [1:0] w);
        exp_t e;
        e.warp  = w;
        e.pc    = model_pc(w);
        e.split = model_split(w);
        exp_q.push_back(e);
    endtask

    // One clock edge, then clear the single-cycle pulses.
    task automatic cycle();
        @(posedge clk);
        #1;
        activate_valid   = 1'b0;
        deactivate_valid = 1'b0;
        resp_valid       = 1'b0;
    endtask

    // Every row with an expected valid in the table is a fresh load that is accepted on the next row.
    task automatic applyStimulus(input vec_t v);
        pc_valid            = v.pc_valid;
        activate_valid      = v.act_v;
        activate_warp_num   = v.act_w;
        deactivate_valid    = v.deact_v;
        deactivate_warp_num = v.deact_w;
        resp_valid          = v.resp_v;
        resp_warp_num       = v.resp_w;
        fetch_if.fetch_ready = v.ready;
        if (v.exp_valid) push_expect(v.exp_warp);
        cycle();
    endtask

    // Scoreboard: compare every accepted request against the oldest expected grant.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && fetch_if.fetch_valid && fetch_if.fetch_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("[TB] FAIL sb_unexpected: got warp %0d pc 0x%0h, expected no request",
                         fetch_if.fetch_warp_num, fetch_if.fetch_pc);
            end else begin
                e = exp_q.pop_front();
                if (fetch_if.fetch_warp_num === e.warp && fetch_if.fetch_pc === e.pc &&
                    fetch_if.fetch_split_table_num === e.split) begin
                    n_pass++;
                end else begin
                    $display("[TB] FAIL sb_accept: got warp %0d pc 0x%0h split %0d, expected warp %0d pc 0x%0h split %0d",
                             fetch_if.fetch_warp_num, fetch_if.fetch_pc, fetch_if.fetch_split_table_num,
                             e.warp, e.pc, e.split);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int w = 0; w < WN; w++) begin
            pc_tab[w]    = model_pc(2'(w));
            split_tab[w] = model_split(2'(w));
        end
        fetch_if.fetch_ready = 1'b0;

        // pc_valid, act, deact, resp, ready | exp valid, warp, active
        vecs[0]  = '{4'hF, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'b0001};
        vecs[1]  = '{4'hF, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd0, 4'b0011};
        vecs[2]  = '{4'hF, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd1, 4'b0111};
        vecs[3]  = '{4'hF, 1'b1, 2'd3, 1'b0, 2'd0, 1'b1, 2'd0, 1'b1, 1'b1, 2'd2, 4'b1111};
        vecs[4]  = '{4'hF, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b1, 1'b1, 2'd3, 4'b1111};
        vecs[5]  = '{4'hF, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd2, 1'b1, 1'b1, 2'd0, 4'b1111};
        vecs[6]  = '{4'h0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd3, 1'b1, 1'b0, 2'd0, 4'b1111};
        vecs[7]  = '{4'h0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b1, 1'b0, 2'd0, 4'b1111};
        vecs[8]  = '{4'h0, 1'b1, 2'd3, 1'b1, 2'd3, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'b0111};
        vecs[9]  = '{4'h0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b1, 1'b0, 2'd0, 4'b0111};
        vecs[10] = '{4'h1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd0, 4'b0111};
        vecs[11] = '{4'h1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd0, 4'b0111};
        vecs[12] = '{4'h0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'b0111};
        vecs[13] = '{4'h0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b1, 1'b0, 2'd0, 4'b0111};
        vecs[14] = '{4'h0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b1, 1'b0, 2'd0, 4'b0111};
        vecs[15] = '{4'h0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'b0110};
        vecs[16] = '{4'h0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'b0100};
        vecs[17] = '{4'h0, 1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'b0000};

`ifdef GELATO_FETCH_GTO_EN
        gto_exp[0] = 2'd0; gto_exp[1] = 2'd0; gto_exp[2] = 2'd1; gto_exp[3] = 2'd1;
`else
        gto_exp[0] = 2'd0; gto_exp[1] = 2'd1; gto_exp[2] = 2'd0; gto_exp[3] = 2'd1;
`endif

        // Reset values.
        #2;
        checkValue("rst_valid", 32'(fetch_if.fetch_valid), 32'd0);
        checkValue("rst_pc", fetch_if.fetch_pc, 32'd0);
        checkValue("rst_warp", 32'(fetch_if.fetch_warp_num), 32'd0);
        checkValue("rst_split", 32'(fetch_if.fetch_split_table_num), 32'd0);
        checkValue("rst_active", 32'(warp_active), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Round-robin order, activation corners and counter saturation from the table.
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_warp, vecs[i].exp_active);
        end

        // Stall: warp 2 held for five cycles, deactivated mid-stall, still accepted afterwards.
        pc_valid = 4'hF;
        fetch_if.fetch_ready = 1'b0;
        activate_valid = 1'b1;
        activate_warp_num = 2'd2;
        cycle();
        checkOutput("stall_latency", 1'b0, 2'd0, 4'b0100);
        cycle();
        push_expect(2'd2);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("stall%0d", i), 1'b1, 2'd2, (i >= 3) ? 4'b0000 : 4'b0100);
            if (i == 2) begin
                deactivate_valid = 1'b1;
                deactivate_warp_num = 2'd2;
            end
            cycle();
        end
        checkOutput("stall_held", 1'b1, 2'd2, 4'b0000);
        fetch_if.fetch_ready = 1'b1;
        cycle();
        checkOutput("stall_accept", 1'b0, 2'd0, 4'b0000);
        resp_valid = 1'b1;
        resp_warp_num = 2'd2;
        cycle();

        // In-flight limit of two on warp 1, then one response frees one slot.
        activate_valid = 1'b1;
        activate_warp_num = 2'd1;
        push_expect(2'd1);
        push_expect(2'd1);
        cycle();
        checkOutput("lim_act", 1'b0, 2'd0, 4'b0010);
        cycle();
        checkOutput("lim_req0", 1'b1, 2'd1, 4'b0010);
        cycle();
        checkOutput("lim_req1", 1'b1, 2'd1, 4'b0010);
        cycle();
        checkOutput("lim_full0", 1'b0, 2'd0, 4'b0010);
        cycle();
        checkOutput("lim_full1", 1'b0, 2'd0, 4'b0010);
        resp_valid = 1'b1;
        resp_warp_num = 2'd1;
        cycle();
        checkOutput("lim_resp", 1'b0, 2'd0, 4'b0010);
        push_expect(2'd1);
        cycle();
        checkOutput("lim_req2", 1'b1, 2'd1, 4'b0010);
        cycle();
        checkOutput("lim_full2", 1'b0, 2'd0, 4'b0010);
        deactivate_valid = 1'b1;
        deactivate_warp_num = 2'd1;
        cycle();
        resp_valid = 1'b1;
        resp_warp_num = 2'd1;
        cycle();
        resp_valid = 1'b1;
        resp_warp_num = 2'd1;
        cycle();

        // Asynchronous reset while a request is held.
        fetch_if.fetch_ready = 1'b0;
        activate_valid = 1'b1;
        activate_warp_num = 2'd0;
        cycle();
        cycle();
        checkOutput("arst_held", 1'b1, 2'd0, 4'b0001);
        #1;
        rst_n = 1'b0;
        #1;
        checkValue("arst_valid", 32'(fetch_if.fetch_valid), 32'd0);
        checkValue("arst_active", 32'(warp_active), 32'd0);
        checkValue("arst_pc", fetch_if.fetch_pc, 32'd0);
        #1;
        rst_n = 1'b1;
        cycle();
        checkOutput("arst_after", 1'b0, 2'd0, 4'b0000);

        // Arbitration order between warps 0 and 1 with no responses.
        fetch_if.fetch_ready = 1'b1;
        pc_valid = 4'h0;
        activate_valid = 1'b1;
        activate_warp_num = 2'd0;
        cycle();
        activate_valid = 1'b1;
        activate_warp_num = 2'd1;
        cycle();
        pc_valid = 4'b0011;
        for (int i = 0; i < 4; i++) push_expect(gto_exp[i]);
        for (int i = 0; i < 4; i++) begin
            cycle();
            checkOutput($sformatf("order%0d", i), 1'b1, gto_exp[i], 4'b0011);
        end
        cycle();
        checkOutput("order_done", 1'b0, 2'd0, 4'b0011);

        checkValue("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/gelato_fetch_warp_arbiter.md
Name: gelato_fetch_warp_arbiter

Overview:
Parametrised successor to the PC-table/fetch-scheduler link. Takes per-warp PC state from the PC table, tracks which warps are active and how many fetches each has in flight, and picks one eligible warp per cycle. Issues that warp's fetch request to I-fetch over a valid/ready handshake. Sits between the PC table and the instruction fetch unit.

Parameters:
WARP_NUM, 8, number of warps tracked.
ADDR_W, 32, PC width.
SPLIT_W, 4, split_table_num width.
MAX_INFLIGHT, 1, maximum outstanding fetches per warp (>=1).
WARP_ID_W, $clog2(WARP_NUM), warp index width.
CNT_W, $clog2(MAX_INFLIGHT+1), per-warp inflight counter width.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
pc_valid  input  WARP_NUM  per-warp PC valid from PC table
pc  input  WARP_NUM x ADDR_W  per-warp PC
split_table_num  input  WARP_NUM x SPLIT_W  per-warp split-table index
activate_valid  input  1  activate a warp this cycle
activate_warp_num  input  WARP_ID_W  warp to activate
deactivate_valid  input  1  deactivate a warp (exit/barrier)
deactivate_warp_num  input  WARP_ID_W  warp to deactivate
fetch_valid  output  1  fetch request valid
fetch_ready  input  1  I-fetch accepts request
fetch_pc  output  ADDR_W  PC of granted warp
fetch_warp_num  output  WARP_ID_W  granted warp
fetch_split_table_num  output  SPLIT_W  granted warp's split index
resp_valid  input  1  fetch completed, release one inflight slot
resp_warp_num  input  WARP_ID_W  warp of completed fetch
warp_active  output  WARP_NUM  per-warp active flags

Behaviour:
- One clock domain. Reset is asynchronous and active-low: clk and rst_n.
- Reset values: all active flags 0, all inflight counters 0, RR pointer 0, fetch_valid 0, fetch_pc/warp_num/split 0, warp_active 0.
- Eligible(w) = active[w] && pc_valid[w] && cnt[w] < MAX_INFLIGHT. Evaluated on current-cycle counters, before this cycle's resp decrement.
- Output register holds the request. Load when !fetch_valid || (fetch_valid && fetch_ready), and only if some warp is eligible.
- On load:
  - capture pc/split of the granted warp.
  - cnt[grant] += 1.
  - pointer <= grant+1, wrapping WARP_NUM-1 -> 0.
- fetch_valid=1 for the cycle after load. Latency: eligible at edge N -> fetch_valid at N+1.
- Handshake: payload stable while fetch_valid && !fetch_ready; no re-arbitration. A held request is never withdrawn, including after deactivation of its warp.
- Accept with no eligible warp -> fetch_valid 0 next cycle.
- Back-to-back: accept and a new load in the same cycle gives continuous fetch_valid.
- Arbitration is round-robin: first eligible warp scanning from pointer upward with wrap.
- Counters:
  - resp_valid decrements cnt[resp_warp_num].
  - Load and resp on the same warp in the same cycle: net unchanged.
  - resp to a warp with cnt 0: ignored, saturates at 0.
  - cnt never exceeds MAX_INFLIGHT.
- Activation:
  - activate sets active, effective next cycle; activating an already-active warp is a no-op.
  - deactivate clears active, effective next cycle; the warp's counter still drains via resp.
  - Same warp activated and deactivated in one cycle: deactivate wins.
- warp_active reflects registered active flags.
- Reset mid-operation: held request dropped, all state returns to reset values immediately (async).

Optional Feature:
Macro GELATO_FETCH_GTO_EN.
- Defined: greedy-then-round-robin. If the last granted warp is still eligible, it is granted again and the pointer is not advanced. Otherwise normal round-robin applies.
- Undefined: strict round-robin as above.

Test Plan:
1. Reset, then WARP_NUM=4, MAX_INFLIGHT=1, activate warps 0..3 with pc_valid=1111, pc[w]=0x100*w, fetch_ready=1, resp one cycle after each accept -> grants 0,1,2,3,0 on consecutive fetch_valid cycles; fetch_pc 0x000,0x100,0x200,0x300.
2. Warp 2 active, fetch_ready=0 for 5 cycles -> fetch_valid=1, fetch_warp_num=2, fetch_pc constant. Deactivate 2 mid-stall -> request still held; accepted on fetch_ready=1, warp_active[2]=0.
3. MAX_INFLIGHT=2, only warp 1 active, no resp -> exactly two accepted requests, then fetch_valid=0. One resp on warp 1 -> one more request issues.
4. Same-cycle activate and deactivate of warp 3 -> warp_active[3]=0. resp on warp 0 with cnt 0 -> no counter underflow, later grant still occurs.
5. Async rst_n pulse while fetch_valid=1 -> fetch_valid=0 and warp_active=0 before the next clk edge.
6. GELATO_FETCH_GTO_EN defined, warps 0 and 1 active, MAX_INFLIGHT=4, no resp -> warp 0 granted 4 times, then warp 1 granted 4 times.
